// File: rtl/dmi_pkg.sv
// dmi_pkg: types and constants shared by both ends of the DMI link (the
// JTAG-side initiator and the debug-module responder).
//   dm_op_e    : request operation encoding (op 3 is reserved and not listed)
//   dm_resp_e  : response code encoding
//   Data0 .. Command : debug register addresses
//   dmi_req_t / dmi_resp_t : packed request and response bundles
package dmi_pkg;

  typedef enum logic [1:0] {
    DMINop   = 2'd0,
    DMIRead  = 2'd1,
    DMIWrite = 2'd2
  } dm_op_e;

  typedef enum logic [1:0] {
    DMINoError = 2'd0,
    DMIFailed  = 2'd2,
    DMIBusy    = 2'd3
  } dm_resp_e;

  localparam logic [6:0] Data0      = 7'h04;
  localparam logic [6:0] DMControl  = 7'h10;
  localparam logic [6:0] DMStatus   = 7'h11;
  localparam logic [6:0] AbstractCS = 7'h16;
  localparam logic [6:0] Command    = 7'h17;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_cmd_timer.sv
// dmi_cmd_timer: abstract-command busy model. A down-counter that is loaded
// with CmdLatency when a command launches and then counts down by one every
// cycle until it reaches zero.
//   tck_i   : clock
//   trst_ni : asynchronous active-low reset
//   load_i  : launch a command (counter <= CmdLatency)
//   clear_i : abort (counter <= 0), wins over load_i
//   busy_o  : counter is nonzero
module dmi_cmd_timer #(
  parameter int unsigned CmdLatency = 4
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic load_i,
  input  logic clear_i,
  output logic busy_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (load_i) begin
      count_d = 8'(CmdLatency);
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != 8'd0);

endmodule

// File: rtl/dmi_responder.sv
// dmi_responder: debug-module end of the DMI link. Accepts one request at a
// time, executes it against a small debug register file on the accept edge,
// and presents a registered response the following cycle.
//   tck_i / trst_ni          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : request handshake (ready only while Idle)
//   req_addr_i/op_i/data_i   : 7-bit address, 2-bit op, 32-bit write data
//   resp_valid_o/ready_i     : response handshake
//   resp_data_o/resp_resp_o  : 32-bit read data, 2-bit response code
//   dmactive_o, haltreq_o    : dmcontrol fields
//   cmd_busy_o               : abstract command in progress
// Optional feature macro: DMI_ADDR_CHECK_EN -- when defined, accesses to
// unmapped addresses (including unimplemented data registers) answer failed.
module dmi_responder
  import dmi_pkg::*;
#(
  parameter int unsigned NumData    = 2,
  parameter int unsigned CmdLatency = 4
) (
  input  logic        tck_i,
  input  logic        trst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  req_addr_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [1:0]  resp_resp_o,
  output logic        dmactive_o,
  output logic        haltreq_o,
  output logic        cmd_busy_o
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StRespond = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] data_q [NumData];
  logic [31:0] data_d [NumData];
  logic        dmactive_q, dmactive_d;
  logic        haltreq_q, haltreq_d;
  logic [2:0]  cmderr_q, cmderr_d;
  dmi_resp_t   resp_q, resp_d;

  logic        accept;
  logic        busy;
  logic        timer_load;
  logic        timer_clear;
  logic        is_read;
  logic        is_write;
  logic        data_hit;
  logic [31:0] data_rd;

  assign req_ready_o  = (state_q == StIdle);
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (state_q == StRespond);
  assign resp_data_o  = resp_q.data;
  assign resp_resp_o  = resp_q.resp;
  assign dmactive_o   = dmactive_q;
  assign haltreq_o    = haltreq_q;
  assign cmd_busy_o   = busy;

  assign is_read  = (req_op_i == DMIRead);
  assign is_write = (req_op_i == DMIWrite);

  dmi_cmd_timer #(
    .CmdLatency(CmdLatency)
  ) u_cmd_timer (
    .tck_i  (tck_i),
    .trst_ni(trst_ni),
    .load_i (timer_load),
    .clear_i(timer_clear),
    .busy_o (busy)
  );

  // Decode the data register window; only implemented registers hit, the
  // rest of 0x04..0x0F falls through to the unmapped handling.
  always_comb begin
    data_hit = 1'b0;
    data_rd  = 32'h0;
    for (int i = 0; i < NumData; i++) begin
      if (req_addr_i == Data0 + 7'(i)) begin
        data_hit = 1'b1;
        data_rd  = data_q[i];
      end
    end
  end

  // Register access happens on the accept edge; the response is captured in
  // the same edge so it is stable for the whole Respond state. Read data is
  // always taken from the current (pre-write) register values.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dmactive_d  = dmactive_q;
    haltreq_d   = haltreq_q;
    cmderr_d    = cmderr_q;
    resp_d      = resp_q;
    timer_load  = 1'b0;
    timer_clear = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StRespond;
          resp_d.data = 32'h0;
          resp_d.resp = DMINoError;
          if (!is_read && !is_write) begin
            if (req_op_i != DMINop) begin
              resp_d.resp = DMIFailed;
            end
          end else if (data_hit) begin
            // Data registers are locked while a command runs; the offending
            // access is reported only if no earlier error is pending.
            if (busy) begin
              resp_d.resp = DMIBusy;
              if (cmderr_q == 3'd0) begin
                cmderr_d = 3'd1;
              end
            end else if (is_read) begin
              resp_d.data = data_rd;
            end else begin
              for (int i = 0; i < NumData; i++) begin
                if (req_addr_i == Data0 + 7'(i)) begin
                  data_d[i] = req_data_i;
                end
              end
            end
          end else begin
            case (req_addr_i)
              DMControl: begin
                if (is_read) begin
                  resp_d.data = {haltreq_q, 30'h0, dmactive_q};
                end else begin
                  dmactive_d = req_data_i[0];
                  haltreq_d  = req_data_i[31];
                  if (!req_data_i[0]) begin
                    for (int i = 0; i < NumData; i++) begin
                      data_d[i] = 32'h0;
                    end
                    cmderr_d    = 3'd0;
                    timer_clear = 1'b1;
                  end
                end
              end
              DMStatus: begin
                if (is_read) begin
                  resp_d.data = {23'h0, haltreq_q, 4'h0, 4'h2};
                end
              end
              AbstractCS: begin
                if (is_read) begin
                  resp_d.data = {19'h0, busy, 1'b0, cmderr_q, 4'h0, 4'(NumData)};
                end else begin
                  cmderr_d = cmderr_q & ~req_data_i[10:8];
                end
              end
              Command: begin
                if (is_write) begin
                  if (busy) begin
                    if (cmderr_q == 3'd0) begin
                      cmderr_d = 3'd1;
                    end
                  end else begin
                    timer_load = 1'b1;
                  end
                end
              end
              default: begin
`ifdef DMI_ADDR_CHECK_EN
                resp_d.resp = DMIFailed;
`else
                resp_d.resp = DMINoError;
`endif
              end
            endcase
          end
        end
      end
      StRespond: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q    <= StIdle;
      dmactive_q <= 1'b0;
      haltreq_q  <= 1'b0;
      cmderr_q   <= 3'd0;
      resp_q     <= '0;
      for (int i = 0; i < NumData; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      dmactive_q <= dmactive_d;
      haltreq_q  <= haltreq_d;
      cmderr_q   <= cmderr_d;
      resp_q     <= resp_d;
      for (int i = 0; i < NumData; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dmi_responder.sv
// tb_dmi_responder: directed test of dmi_responder with NumData=2 and
// CmdLatency=4. Inputs change on the falling edge, outputs are sampled on
// the falling edge. Unmapped-access expectations follow DMI_ADDR_CHECK_EN.
module tb_dmi_responder;

  logic        tck;
  logic        trst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;
  logic        dmactive;
  logic        haltreq;
  logic        cmd_busy;

  int total = 0;
  int bad   = 0;

`ifdef DMI_ADDR_CHECK_EN
  localparam logic [1:0] UnmappedResp = 2'd2;
`else
  localparam logic [1:0] UnmappedResp = 2'd0;
`endif

  dmi_responder #(
    .NumData   (2),
    .CmdLatency(4)
  ) dut (
    .tck_i       (tck),
    .trst_ni     (trst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_op_i    (req_op),
    .req_data_i  (req_data),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .resp_resp_o (resp_resp),
    .dmactive_o  (dmactive),
    .haltreq_o   (haltreq),
    .cmd_busy_o  (cmd_busy)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // One full transaction with an always-ready consumer. vld is 1 only if the
  // response was absent before the accept edge and present right after it.
  task automatic xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                      output logic [1:0] rr, output logic [31:0] rd, output logic vld);
    int   w;
    logic pre;
    @(negedge tck);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_data   = wd;
    resp_ready = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge tck);
      w++;
    end
    pre = resp_valid;
    @(posedge tck);
    #1 req_valid = 1'b0;
    @(negedge tck);
    vld = !pre && resp_valid && (w < 20);
    rr  = resp_resp;
    rd  = resp_data;
    @(posedge tck);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    trst_n     = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 7'h0;
    req_op     = 2'd0;
    req_data   = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge tck);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++;
    if ({resp_data, resp_resp} !== 34'h0) begin bad++; $display("[TB] FAIL reset_resp got=%h/%h exp=0/0", resp_data, resp_resp); end
    total++;
    if ({dmactive, haltreq, cmd_busy} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {dmactive, haltreq, cmd_busy}); end
    trst_n = 1'b1;
    @(negedge tck);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_data_rw();
    logic [1:0] rr; logic [31:0] rd; logic v;
    xact(2'd2, 7'h04, 32'hDEADBEEF, rr, rd, v);
    total++;
    if (v !== 1'b1 || rr !== 2'd0) begin bad++; $display("[TB] FAIL wr_data0 got=v%b/%h exp=v1/0", v, rr); end
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (v !== 1'b1 || rr !== 2'd0 || rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data0 got=v%b/%h/%h exp=v1/0/deadbeef", v, rr, rd); end
    xact(2'd2, 7'h05, 32'h12345678, rr, rd, v);
    xact(2'd1, 7'h05, 32'h0, rr, rd, v);
    total++;
    if (v !== 1'b1 || rr !== 2'd0 || rd !== 32'h12345678) begin bad++; $display("[TB] FAIL rd_data1 got=v%b/%h/%h exp=v1/0/12345678", v, rr, rd); end
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data0_again got=%h exp=deadbeef", rd); end
    xact(2'd0, 7'h04, 32'hFFFFFFFF, rr, rd, v);
    total++;
    if (v !== 1'b1 || rr !== 2'd0 || rd !== 32'h0) begin bad++; $display("[TB] FAIL nop got=v%b/%h/%h exp=v1/0/0", v, rr, rd); end
  endtask

  task automatic test_busy();
    logic [1:0] rr; logic [31:0] rd; logic v;
    xact(2'd2, 7'h17, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0 || cmd_busy !== 1'b1) begin bad++; $display("[TB] FAIL cmd_launch got=%h/busy%b exp=0/busy1", rr, cmd_busy); end
    xact(2'd2, 7'h05, 32'hCAFEF00D, rr, rd, v);
    total++;
    if (rr !== 2'd3 || rd !== 32'h0) begin bad++; $display("[TB] FAIL wr_while_busy got=%h/%h exp=3/0", rr, rd); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00001102) begin bad++; $display("[TB] FAIL abscs_busy got=%h exp=00001102", rd); end
    repeat (4) @(negedge tck);
    total++;
    if (cmd_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_expired got=%b exp=0", cmd_busy); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000102) begin bad++; $display("[TB] FAIL abscs_idle got=%h exp=00000102", rd); end
    xact(2'd2, 7'h16, 32'h00000700, rr, rd, v);
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000002) begin bad++; $display("[TB] FAIL cmderr_w1c got=%h exp=00000002", rd); end
    // Counter is 1 at the data access, so it must still be reported busy.
    xact(2'd2, 7'h17, 32'h0, rr, rd, v);
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00001002) begin bad++; $display("[TB] FAIL abscs_busy_noerr got=%h exp=00001002", rd); end
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd3 || rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_last_busy got=%h/%h exp=3/0", rr, rd); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000102) begin bad++; $display("[TB] FAIL abscs_after_edge got=%h exp=00000102", rd); end
    xact(2'd2, 7'h16, 32'h00000700, rr, rd, v);
    xact(2'd1, 7'h05, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0 || rd !== 32'h12345678) begin bad++; $display("[TB] FAIL data1_untouched got=%h/%h exp=0/12345678", rr, rd); end
    xact(2'd1, 7'h17, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0 || rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_command got=%h/%h exp=0/0", rr, rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge tck);
    req_valid  = 1'b1;
    req_op     = 2'd1;
    req_addr   = 7'h04;
    resp_ready = 1'b0;
    @(posedge tck);
    for (int i = 0; i < 5; i++) begin
      @(negedge tck);
      total++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_resp !== 2'd0)
        begin bad++; $display("[TB] FAIL hold_%0d got=rdy%b/v%b/%h/%h exp=rdy0/v1/deadbeef/0", i, req_ready, resp_valid, resp_data, resp_resp); end
    end
    resp_ready = 1'b1;
    @(posedge tck);
    #1 req_addr = 7'h10;
    resp_ready = 1'b0;
    @(negedge tck);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL after_handshake got=rdy%b/v%b exp=rdy1/v0", req_ready, resp_valid); end
    @(posedge tck);
    #1 req_valid = 1'b0;
    @(negedge tck);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin bad++; $display("[TB] FAIL next_accept got=v%b/%h exp=v1/0", resp_valid, resp_data); end
    resp_ready = 1'b1;
    @(posedge tck);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_dmcontrol();
    logic [1:0] rr; logic [31:0] rd; logic v;
    xact(2'd2, 7'h04, 32'hA5A5A5A5, rr, rd, v);
    xact(2'd2, 7'h10, 32'h80000001, rr, rd, v);
    total++;
    if (haltreq !== 1'b1 || dmactive !== 1'b1) begin bad++; $display("[TB] FAIL dmctrl_out got=h%b/a%b exp=h1/a1", haltreq, dmactive); end
    xact(2'd1, 7'h10, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h80000001) begin bad++; $display("[TB] FAIL rd_dmctrl got=%h exp=80000001", rd); end
    xact(2'd1, 7'h11, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000102) begin bad++; $display("[TB] FAIL rd_dmstatus got=%h exp=00000102", rd); end
    xact(2'd2, 7'h11, 32'hFFFFFFFF, rr, rd, v);
    xact(2'd1, 7'h11, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0 || rd !== 32'h00000102) begin bad++; $display("[TB] FAIL dmstatus_ro got=%h/%h exp=0/00000102", rr, rd); end
    xact(2'd2, 7'h17, 32'h0, rr, rd, v);
    xact(2'd2, 7'h17, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0) begin bad++; $display("[TB] FAIL cmd_while_busy got=%h exp=0", rr); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00001102) begin bad++; $display("[TB] FAIL cmd_busy_cmderr got=%h exp=00001102", rd); end
    xact(2'd2, 7'h10, 32'h0, rr, rd, v);
    total++;
    if (haltreq !== 1'b0 || dmactive !== 1'b0) begin bad++; $display("[TB] FAIL dmctrl_clear got=h%b/a%b exp=h0/a0", haltreq, dmactive); end
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (rr !== 2'd0 || rd !== 32'h0) begin bad++; $display("[TB] FAIL data0_cleared got=%h/%h exp=0/0", rr, rd); end
    xact(2'd1, 7'h05, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h0) begin bad++; $display("[TB] FAIL data1_cleared got=%h exp=0", rd); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000002) begin bad++; $display("[TB] FAIL cmderr_cleared got=%h exp=00000002", rd); end
  endtask

  task automatic test_reserved_unmapped();
    logic [1:0] rr; logic [31:0] rd; logic v;
    xact(2'd2, 7'h04, 32'h11112222, rr, rd, v);
    xact(2'd3, 7'h04, 32'hFFFFFFFF, rr, rd, v);
    total++;
    if (rr !== 2'd2 || rd !== 32'h0) begin bad++; $display("[TB] FAIL reserved_op got=%h/%h exp=2/0", rr, rd); end
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h11112222) begin bad++; $display("[TB] FAIL reserved_nochange got=%h exp=11112222", rd); end
    xact(2'd1, 7'h7F, 32'h0, rr, rd, v);
    total++;
    if (rr !== UnmappedResp || rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_unmapped got=%h/%h exp=%h/0", rr, rd, UnmappedResp); end
    xact(2'd2, 7'h7F, 32'hFFFFFFFF, rr, rd, v);
    total++;
    if (rr !== UnmappedResp) begin bad++; $display("[TB] FAIL wr_unmapped got=%h exp=%h", rr, UnmappedResp); end
    xact(2'd1, 7'h06, 32'h0, rr, rd, v);
    total++;
    if (rr !== UnmappedResp || rd !== 32'h0) begin bad++; $display("[TB] FAIL rd_data_oob got=%h/%h exp=%h/0", rr, rd, UnmappedResp); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] rr; logic [31:0] rd; logic v;
    xact(2'd2, 7'h10, 32'h80000001, rr, rd, v);
    @(negedge tck);
    req_valid  = 1'b1;
    req_op     = 2'd1;
    req_addr   = 7'h04;
    resp_ready = 1'b0;
    @(posedge tck);
    #1 req_valid = 1'b0;
    @(negedge tck);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h11112222) begin bad++; $display("[TB] FAIL pre_reset_resp got=v%b/%h exp=v1/11112222", resp_valid, resp_data); end
    trst_n = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || dmactive !== 1'b0 || haltreq !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got=v%b/a%b/h%b exp=0/0/0", resp_valid, dmactive, haltreq); end
    #6 trst_n = 1'b1;
    xact(2'd1, 7'h04, 32'h0, rr, rd, v);
    total++;
    if (v !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_data0 got=v%b/%h exp=v1/0", v, rd); end
    xact(2'd1, 7'h10, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_dmctrl got=%h exp=0", rd); end
    xact(2'd1, 7'h16, 32'h0, rr, rd, v);
    total++;
    if (rd !== 32'h00000002) begin bad++; $display("[TB] FAIL post_reset_abscs got=%h exp=00000002", rd); end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_busy();
    test_back_to_back();
    test_dmcontrol();
    test_reserved_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
